acc_seq: RTL and testbench

Parametrised sequenced accumulator: a WIDTH-bit register updated by single-cycle commands (load, add, increment, decrement) and by a multi-cycle repeated-add command that computes acc + a·b by b successive additions. Sits in the datapath as the next-generation accumulator register. It adds a command/ready handshake, a completion pulse, a sticky overflow flag and optional saturation.

---
 rtl/acc_seq.sv | 121 ++++++++++++
 tb/tb_acc_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/acc_seq.sv
// acc_seq: sequenced WIDTH-bit accumulator with single-cycle LOAD/ADD/INC/DEC/CLRF and multi-cycle RADD (acc + a*b by b adds).
// Latency: single-cycle ops update acc/ovf at the accepting edge and pulse done for one cycle; RADD takes b cycles (b=0 -> done next cycle).
// Backpressure: ready is low while a RADD runs; start during RUN is ignored (not queued).
//
// Ports: clk, nrst (sync active-low), start/op/a/b command inputs,
//        acc (registered value), ready (idle), done (result pulse), ovf (sticky flag).
// Optional build macro: ACC_SAT_EN -> saturating arithmetic (clamp to max on carry, to 0 on borrow).
module acc_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc,
  output logic             ready,
  output logic             done,
  output logic             ovf
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_RADD = 3'd5;
  localparam logic [2:0] OP_CLRF = 3'd6;

  logic [0:0]       state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] a_q;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;

  assign ready = (state == IDLE);

  // One shared adder: in RUN it adds the latched operand, in IDLE it
  // serves ADD (a) and INC (constant 1). The extra MSB is carry/borrow.
  always_comb begin
    addend  = (state == RUN) ? a_q : ((op == OP_INC) ? WIDTH'(1) : a);
    sum     = {1'b0, acc} + {1'b0, addend};
    diff    = {1'b0, acc} - {1'b0, WIDTH'(1)};
    add_res = sum[WIDTH-1:0];
    sub_res = diff[WIDTH-1:0];
`ifdef ACC_SAT_EN
    // Once clamped at max, further RADD steps carry again and stay clamped.
    if (sum[WIDTH])  add_res = '1;
    if (diff[WIDTH]) sub_res = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      a_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_LOAD: begin
                acc  <= a;
                done <= 1'b1;
              end
              OP_ADD, OP_INC: begin
                acc  <= add_res;
                if (sum[WIDTH]) ovf <= 1'b1;
                done <= 1'b1;
              end
              OP_DEC: begin
                acc  <= sub_res;
                if (diff[WIDTH]) ovf <= 1'b1;
                done <= 1'b1;
              end
              OP_RADD: begin
                if (b == '0) begin
                  done <= 1'b1;
                end else begin
                  a_q   <= a;
                  count <= b;
                  state <= RUN;
                end
              end
              OP_CLRF: begin
                ovf  <= 1'b0;
                done <= 1'b1;
              end
              default: ; // NOP and reserved code: nothing changes
            endcase
          end
        end
        RUN: begin
          acc   <= add_res;
          if (sum[WIDTH]) ovf <= 1'b1;
          count <= count - WIDTH'(1);
          // count==1 means this edge performs the b-th and final addition.
          if (count == WIDTH'(1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_seq.sv
// tb_acc_seq: directed test-plan steps followed by random commands, every
// cycle compared against an integer-arithmetic reference model.
module tb_acc_seq;
  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk   = 1'b0;
  logic         nrst  = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op    = 3'd0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] acc;
  logic         ready;
  logic         done;
  logic         ovf;

  acc_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .acc  (acc),
    .ready(ready),
    .done (done),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: acc as a plain integer, remaining RADD additions as a count.
  int m_acc   = 0;
  int m_busy  = 0;
  int m_alat  = 0;
  bit m_ovf   = 1'b0;
  bit m_done  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_add(input int y);
    int s;
    s = m_acc + y;
    if (s > MAXV) begin
      m_ovf = 1'b1;
`ifdef ACC_SAT_EN
      s = MAXV;
`else
      s = s - (MAXV + 1);
`endif
    end
    m_acc = s;
  endtask

  task automatic m_dec();
    int s;
    s = m_acc - 1;
    if (s < 0) begin
      m_ovf = 1'b1;
`ifdef ACC_SAT_EN
      s = 0;
`else
      s = MAXV;
`endif
    end
    m_acc = s;
  endtask

  task automatic model(input bit rn, input bit st, input int o, input int ia, input int ib);
    if (!rn) begin
      m_acc = 0; m_ovf = 0; m_done = 0; m_busy = 0;
    end else begin
      m_done = 0;
      if (m_busy > 0) begin
        m_add(m_alat);
        m_busy--;
        if (m_busy == 0) m_done = 1;
      end else if (st) begin
        case (o)
          1: begin m_acc = ia; m_done = 1; end
          2: begin m_add(ia); m_done = 1; end
          3: begin m_add(1); m_done = 1; end
          4: begin m_dec(); m_done = 1; end
          5: begin
            if (ib == 0) m_done = 1;
            else begin m_alat = ia; m_busy = ib; end
          end
          6: begin m_ovf = 0; m_done = 1; end
          default: ;
        endcase
      end
    end
  endtask

  // Apply one cycle of inputs, clock it, then compare all outputs with the model.
  task automatic step(input string tag, input bit rn, input bit st, input int o, input int ia, input int ib);
    nrst  = rn;
    start = st;
    op    = 3'(o);
    a     = W'(ia);
    b     = W'(ib);
    @(posedge clk);
    #1;
    model(rn, st, o, ia, ib);
    chk({tag, ".acc"},   32'(acc),   32'(m_acc));
    chk({tag, ".ready"}, 32'(ready), 32'(m_busy == 0));
    chk({tag, ".done"},  32'(done),  32'(m_done));
    chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
  endtask

  initial begin
    // Reset
    step("rst0", 0, 0, 0, 0, 0);
    step("rst1", 0, 1, 1, 9, 0);
    chk("reset_acc", 32'(acc), 32'd0);
    chk("reset_ready", 32'(ready), 32'd1);

    // LOAD 5, ADD 3 back-to-back
    step("load5", 1, 1, 1, 5, 0);
    chk("plan_load5", 32'(acc), 32'd5);
    step("add3", 1, 1, 2, 3, 0);
    chk("plan_add3", 32'(acc), 32'd8);
    chk("plan_add3_done", 32'(done), 32'd1);

    // Overflow on INC, then CLRF
    step("load15", 1, 1, 1, 15, 0);
    step("inc", 1, 1, 3, 0, 0);
`ifdef ACC_SAT_EN
    chk("plan_inc_acc", 32'(acc), 32'd15);
`else
    chk("plan_inc_acc", 32'(acc), 32'd0);
`endif
    chk("plan_inc_ovf", 32'(ovf), 32'd1);
    step("clrf", 1, 1, 6, 0, 0);
    chk("plan_clrf", 32'(ovf), 32'd0);

    // Mid-stream reset
    step("rst_mid", 0, 1, 2, 4, 0);
    chk("plan_rst_acc", 32'(acc), 32'd0);

    // LOAD 1, RADD a=3 b=4 with LOAD held during RUN
    step("load1", 1, 1, 1, 1, 0);
    step("radd34", 1, 1, 5, 3, 4);
    chk("plan_radd_busy", 32'(ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step("radd_run", 1, 1, 1, 15, 2);
      chk("plan_radd_acc", 32'(acc), 32'(4 + 3 * i));
      chk("plan_radd_done", 32'(done), 32'(i == 3));
    end
    step("radd_after", 1, 0, 0, 0, 0);
    chk("plan_radd_hold", 32'(acc), 32'd13);

    // RADD with b=0
    step("load9", 1, 1, 1, 9, 0);
    step("radd_b0", 1, 1, 5, 5, 0);
    chk("plan_b0_acc", 32'(acc), 32'd9);
    chk("plan_b0_ready", 32'(ready), 32'd1);
    chk("plan_b0_done", 32'(done), 32'd1);
    step("nop", 1, 0, 5, 5, 0);

    // Reset during RUN aborts without done
    step("load0", 1, 1, 1, 0, 0);
    step("radd26", 1, 1, 5, 2, 6);
    step("run1", 1, 0, 0, 0, 0);
    step("run2", 1, 0, 0, 0, 0);
    chk("plan_abort_mid", 32'(acc), 32'd4);
    step("run3_rst", 0, 0, 0, 0, 0);
    chk("plan_abort_acc", 32'(acc), 32'd0);
    chk("plan_abort_done", 32'(done), 32'd0);
    step("load7", 1, 1, 1, 7, 0);
    chk("plan_load7", 32'(acc), 32'd7);

    // Random commands
    for (int i = 0; i < 600; i++) begin
      step("rand",
           $urandom_range(0, 39) != 0,
           $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, MAXV)),
           int'($urandom_range(0, 5)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
